// File: rtl/main_memory_arbiter_if.sv
// Bus bundle between the I/D cache controllers, the arbiter and the main memory model.
// The arbiter connects through the slave modport; the requesters and memory side use master.
interface main_memory_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  icache_req;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_done;
  logic [DATA_WIDTH-1:0] icache_rdata;
  logic                  dcache_req;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [DATA_WIDTH-1:0] dcache_wdata;
  logic                  dcache_we;
  logic                  dcache_done;
  logic [DATA_WIDTH-1:0] dcache_rdata;
  logic [ADDR_WIDTH-1:0] mem_Address;
  logic [DATA_WIDTH-1:0] mem_Data;
  logic                  mem_ismemWrite;
  logic [DATA_WIDTH-1:0] mem_outputmem;
  logic                  busy;

  modport master (
    output icache_req, icache_addr, dcache_req, dcache_addr, dcache_wdata, dcache_we,
           mem_outputmem,
    input  icache_done, icache_rdata, dcache_done, dcache_rdata, mem_Address, mem_Data,
           mem_ismemWrite, busy
  );

  modport slave (
    input  icache_req, icache_addr, dcache_req, dcache_addr, dcache_wdata, dcache_we,
           mem_outputmem,
    output icache_done, icache_rdata, dcache_done, dcache_rdata, mem_Address, mem_Data,
           mem_ismemWrite, busy
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// Shares one main-memory port between the I and D caches; round-robin on ties by default,
// or fixed D priority when DCACHE_PRIORITY_EN is defined.
module main_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic                    clk,
  input logic                    reset,
  main_memory_arbiter_if.slave   bus
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  gnt_dc_q, gnt_dc_d;  // 1: D port owns the current access
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  pick_dc;

`ifdef DCACHE_PRIORITY_EN
  assign pick_dc = bus.dcache_req;
`else
  logic last_dc_q, last_dc_d;

  // Tie goes to whichever port was not granted last.
  assign pick_dc = bus.dcache_req & (~bus.icache_req | ~last_dc_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc_q <= 1'b1;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end

  always_comb begin
    last_dc_d = last_dc_q;
    if (state_q == StIdle && (bus.icache_req || bus.dcache_req)) begin
      last_dc_d = pick_dc;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_dc_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_dc_q  <= gnt_dc_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_dc_d  = gnt_dc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.icache_req || bus.dcache_req) begin
          state_d  = StAccess;
          cnt_d    = '0;
          gnt_dc_d = pick_dc;
          addr_d   = pick_dc ? bus.dcache_addr : bus.icache_addr;
          // I accesses are always reads with zero data on the bus.
          wdata_d  = pick_dc ? bus.dcache_wdata : '0;
          we_d     = pick_dc & bus.dcache_we;
        end
      end
      StAccess: begin
        if (cnt_q == CntLast) begin
          state_d = StRespond;
          cnt_d   = '0;
          if (!we_q) begin
            if (gnt_dc_q) d_rdata_d = bus.mem_outputmem;
            else          i_rdata_d = bus.mem_outputmem;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  logic in_access;
  assign in_access = (state_q == StAccess);

  // Bus is forced to zero outside ACCESS so a write can never leak.
  assign bus.mem_Address    = in_access ? addr_q : '0;
  assign bus.mem_Data       = in_access ? wdata_q : '0;
  assign bus.mem_ismemWrite = in_access & we_q;
  assign bus.icache_done    = (state_q == StRespond) & ~gnt_dc_q;
  assign bus.dcache_done    = (state_q == StRespond) & gnt_dc_q;
  assign bus.icache_rdata   = i_rdata_q;
  assign bus.dcache_rdata   = d_rdata_q;
  assign bus.busy           = (state_q != StIdle);

endmodule
